// File: rtl/mjpg_byte_streamer.sv
// MJPEG bitstream word FIFO and SOI..EOI framed byte serializer with overflow resync.
// Optional: MJPG_BYTE_STREAMER_ABORT_EOI_EN closes truncated frames with FF D9 + terr.
module mjpg_byte_streamer #(
    parameter int FIFO_AW = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bsvalid,
    input  logic [31:0]      bsdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tlast,
    output logic             m_terr,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif

    typedef enum logic {IN_PASS, IN_DROP} in_st_t;
    typedef enum logic {SR_HUNT, SR_STREAM} sr_st_t;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wptr;
    logic [FIFO_AW:0]   r_rptr;
    logic [FIFO_AW:0]   w_count;
    logic [FIFO_AW:0]   w_winc;
    logic               w_full;
    logic               w_empty;
    logic               w_room;
    logic [DW-1:0]      w_head;

    in_st_t             r_in_st;
    in_st_t             w_in_nxt;
    logic               r_last_ff;
    logic               w_soi;
    logic               w_wr;
    logic               w_drop;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_cnt;

    sr_st_t             r_sr_st;
    sr_st_t             w_sr_nxt;
    logic [23:0]        r_word;
    logic [1:0]         r_bcnt;
    logic               r_pend_ff;
    logic               r_prev_ff;
    logic               w_pend_nxt;
    logic               w_prev_nxt;
    logic               w_load;
    logic               w_from_word;
    logic               w_avail;
    logic [7:0]         w_byte;
    logic               w_consume;
    logic               w_pop;
    logic               w_emit;
    logic [7:0]         w_ebyte;
    logic               w_elast;
    logic               r_tvalid;
    logic [7:0]         r_tdata;
    logic               r_tlast;
    logic [CNT_W-1:0]   r_frame_cnt;

`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    logic               w_wr_abort;
    logic [FIFO_AW:0]   w_wptr_p1;
    logic               w_is_abort;
    logic               w_pop_abort;
    logic               r_abt;
    logic               w_abt_nxt;
    logic               w_eerr;
    logic               r_terr;
`endif

    assign w_count = r_wptr - r_rptr;
    assign w_full  = w_count[FIFO_AW];
    assign w_empty = (w_count == '0);
    assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    // Recovery needs room for the abort entry and the SOI word together.
    assign w_room    = w_count < (FIFO_AW+1)'(DEPTH - 1);
    assign w_wptr_p1 = r_wptr + (FIFO_AW+1)'(1);
`else
    assign w_room    = !w_full;
`endif

    assign w_soi = (r_last_ff && bsdata[31:24] == 8'hD8)
                || (bsdata[31:24] == 8'hFF && bsdata[23:16] == 8'hD8)
                || (bsdata[23:16] == 8'hFF && bsdata[15:8] == 8'hD8)
                || (bsdata[15:8] == 8'hFF && bsdata[7:0] == 8'hD8);

    always_comb begin
        w_in_nxt = r_in_st;
        w_wr     = 1'b0;
        w_drop   = 1'b0;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
        w_wr_abort = 1'b0;
`endif
        unique case (r_in_st)
            IN_PASS: begin
                if (bsvalid) begin
                    if (!w_full) begin
                        w_wr = 1'b1;
                    end else begin
                        w_drop   = 1'b1;
                        w_in_nxt = IN_DROP;
                    end
                end
            end
            IN_DROP: begin
                if (bsvalid) begin
                    if (w_soi && w_room) begin
                        w_wr     = 1'b1;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
                        w_wr_abort = 1'b1;
`endif
                        w_in_nxt = IN_PASS;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_winc = '0;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
        if (w_wr_abort)
            w_winc = (FIFO_AW+1)'(2);
        else if (w_wr)
            w_winc = (FIFO_AW+1)'(1);
`else
        if (w_wr)
            w_winc = (FIFO_AW+1)'(1);
`endif
    end

    always_ff @(posedge clk) begin
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
        if (w_wr_abort) begin
            r_mem[r_wptr[FIFO_AW-1:0]]    <= {1'b1, 32'h0};
            r_mem[w_wptr_p1[FIFO_AW-1:0]] <= {1'b0, bsdata};
        end else if (w_wr) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= {1'b0, bsdata};
        end
`else
        if (w_wr)
            r_mem[r_wptr[FIFO_AW-1:0]] <= bsdata;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_st    <= IN_PASS;
            r_wptr     <= '0;
            r_last_ff  <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_in_st <= w_in_nxt;
            r_wptr  <= r_wptr + w_winc;
            if (bsvalid)
                r_last_ff <= (bsdata[7:0] == 8'hFF);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}})
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign w_load      = !r_tvalid || m_tready;
    assign w_from_word = (r_bcnt != 2'd0);
    assign w_avail     = w_from_word || !w_empty;
    assign w_byte      = w_from_word ? r_word[23:16] : w_head[31:24];
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    assign w_is_abort  = !w_from_word && !w_empty && w_head[32];
    assign w_pop       = (w_consume && !w_from_word) || w_pop_abort;
`else
    assign w_pop       = w_consume && !w_from_word;
`endif

    always_comb begin
        w_sr_nxt   = r_sr_st;
        w_pend_nxt = r_pend_ff;
        w_prev_nxt = r_prev_ff;
        w_consume  = 1'b0;
        w_emit     = 1'b0;
        w_ebyte    = 8'h00;
        w_elast    = 1'b0;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
        w_pop_abort = 1'b0;
        w_abt_nxt   = r_abt;
        w_eerr      = 1'b0;
`endif
        unique case (r_sr_st)
            SR_HUNT: begin
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
                if (w_is_abort) begin
                    w_pop_abort = 1'b1;
                    w_pend_nxt  = 1'b0;
                end else
`endif
                if (w_avail) begin
                    // The D8 is left in place and emitted from STREAM.
                    if (r_pend_ff && w_byte == 8'hD8) begin
                        if (w_load) begin
                            w_emit     = 1'b1;
                            w_ebyte    = 8'hFF;
                            w_sr_nxt   = SR_STREAM;
                            w_prev_nxt = 1'b1;
                            w_pend_nxt = 1'b0;
                        end
                    end else begin
                        w_consume  = 1'b1;
                        w_pend_nxt = (w_byte == 8'hFF);
                    end
                end
            end
            SR_STREAM: begin
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
                if (r_abt) begin
                    if (w_load) begin
                        w_emit    = 1'b1;
                        w_ebyte   = 8'hD9;
                        w_elast   = 1'b1;
                        w_eerr    = 1'b1;
                        w_abt_nxt = 1'b0;
                        w_sr_nxt  = SR_HUNT;
                    end
                end else if (w_is_abort) begin
                    if (w_load) begin
                        w_emit      = 1'b1;
                        w_ebyte     = 8'hFF;
                        w_pop_abort = 1'b1;
                        w_abt_nxt   = 1'b1;
                    end
                end else
`endif
                if (w_avail && w_load) begin
                    w_emit     = 1'b1;
                    w_ebyte    = w_byte;
                    w_consume  = 1'b1;
                    w_prev_nxt = (w_byte == 8'hFF);
                    if (r_prev_ff && w_byte == 8'hD9) begin
                        w_elast    = 1'b1;
                        w_sr_nxt   = SR_HUNT;
                        w_pend_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr_st     <= SR_HUNT;
            r_rptr      <= '0;
            r_word      <= '0;
            r_bcnt      <= 2'd0;
            r_pend_ff   <= 1'b0;
            r_prev_ff   <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tdata     <= 8'h00;
            r_tlast     <= 1'b0;
            r_frame_cnt <= '0;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
            r_abt       <= 1'b0;
            r_terr      <= 1'b0;
`endif
        end else begin
            r_sr_st   <= w_sr_nxt;
            r_pend_ff <= w_pend_nxt;
            r_prev_ff <= w_prev_nxt;
            r_rptr    <= r_rptr + {{FIFO_AW{1'b0}}, w_pop};
            if (w_consume) begin
                if (w_from_word) begin
                    r_word <= {r_word[15:0], 8'h00};
                    r_bcnt <= r_bcnt - 2'd1;
                end else begin
                    r_word <= w_head[23:0];
                    r_bcnt <= 2'd3;
                end
            end
            if (w_load) begin
                r_tvalid <= w_emit;
                if (w_emit) begin
                    r_tdata <= w_ebyte;
                    r_tlast <= w_elast;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
                    r_terr  <= w_eerr;
`endif
                end
            end
            if (r_tvalid && m_tready && r_tlast)
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
            r_abt <= w_abt_nxt;
`endif
        end
    end

    assign m_tvalid  = r_tvalid;
    assign m_tdata   = r_tdata;
    assign m_tlast   = r_tlast;
`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    assign m_terr    = r_terr;
`else
    assign m_terr    = 1'b0;
`endif
    assign overflow  = r_overflow;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mjpg_byte_streamer.sv
// Self-checking bench for mjpg_byte_streamer: vector table plus byte scoreboard.
// Honours MJPG_BYTE_STREAMER_ABORT_EOI_EN for the overflow expectations.
module tb_mjpg_byte_streamer;

    localparam int AW = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bsvalid = 1'b0;
    logic [31:0]   bsdata = '0;
    logic          m_tready = 1'b0;
    logic          m_tvalid;
    logic [7:0]    m_tdata;
    logic          m_tlast;
    logic          m_terr;
    logic          overflow;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;

    mjpg_byte_streamer #(.FIFO_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bsvalid(bsvalid), .bsdata(bsdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_terr(m_terr), .overflow(overflow),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       e;
    } beat_t;

    typedef struct {
        int          sc;
        logic [31:0] w;
        int          n;
        logic [39:0] b;
        logic [4:0]  l;
    } vec_t;

    beat_t sbq[$];
    vec_t  vt[12];
    int    n_tests = 0;
    int    n_fail = 0;
    bit    tog = 1'b0;

`ifdef MJPG_BYTE_STREAMER_ABORT_EOI_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic e);
        beat_t bt;
        bt.d = d;
        bt.l = l;
        bt.e = e;
        sbq.push_back(bt);
    endtask

    task automatic push_vec(input vec_t v);
        for (int i = 0; i < v.n; i++)
            push(v.b[39-8*i -: 8], v.l[4-i], 1'b0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            push(w[31-8*i -: 8], 1'b0, 1'b0);
    endtask

    task automatic drive(input logic [31:0] w);
        @(posedge clk);
        #1;
        bsvalid = 1'b1;
        bsdata  = w;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bsvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bsvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic wait_drain(input int maxc);
        int c;
        c = 0;
        while (sbq.size() != 0 && c < maxc) begin
            @(posedge clk);
            c++;
        end
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, want 0", sbq.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on handshake and hold-stability check while stalled.
    logic       p_v = 1'b0;
    logic       p_r = 1'b0;
    logic       p_rst = 1'b1;
    logic [7:0] p_d = '0;
    logic       p_l = 1'b0;
    logic       p_e = 1'b0;

    initial begin
        beat_t ex;
        forever begin
            @(negedge clk);
            if (!rst && !p_rst && p_v && !p_r) begin
                n_tests++;
                if (!m_tvalid || m_tdata !== p_d || m_tlast !== p_l || m_terr !== p_e) begin
                    n_fail++;
                    $display("FAIL stall: got v%0b %02h l%0b e%0b want v1 %02h l%0b e%0b",
                             m_tvalid, m_tdata, m_tlast, m_terr, p_d, p_l, p_e);
                end
            end
            if (!rst && m_tvalid && m_tready) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: got %02h l%0b e%0b want none", m_tdata, m_tlast, m_terr);
                end else begin
                    ex = sbq.pop_front();
                    if (m_tdata !== ex.d || m_tlast !== ex.l || m_terr !== ex.e) begin
                        n_fail++;
                        $display("FAIL beat: got %02h l%0b e%0b want %02h l%0b e%0b",
                                 m_tdata, m_tlast, m_terr, ex.d, ex.l, ex.e);
                    end
                end
            end
            p_v = m_tvalid;
            p_r = m_tready;
            p_rst = rst;
            p_d = m_tdata;
            p_l = m_tlast;
            p_e = m_terr;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog)
                m_tready = ~m_tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{0, 32'h12FFD9FF, 0, 40'h0, 5'b00000};
        vt[1]  = '{0, 32'hD8AABBCC, 5, 40'hFFD8AABBCC, 5'b00000};
        vt[2]  = '{0, 32'hFFD90000, 2, 40'hFFD9000000, 5'b01000};
        vt[3]  = '{1, 32'h000000FF, 0, 40'h0, 5'b00000};
        vt[4]  = '{1, 32'hD8FF0001, 5, 40'hFFD8FF0001, 5'b00000};
        vt[5]  = '{1, 32'h02FFD9FF, 3, 40'h02FFD90000, 5'b00100};
        vt[6]  = '{2, 32'hFFD81122, 4, 40'hFFD8112200, 5'b00000};
        vt[7]  = '{2, 32'h33FF0044, 4, 40'h33FF004400, 5'b00000};
        vt[8]  = '{2, 32'h55FFD9AA, 3, 40'h55FFD90000, 5'b00100};
        vt[9]  = '{3, 32'hFFD801FF, 4, 40'hFFD801FF00, 5'b00000};
        vt[10] = '{3, 32'hD9FFD802, 4, 40'hD9FFD80200, 5'b10000};
        vt[11] = '{3, 32'hFFD90000, 2, 40'hFFD9000000, 5'b01000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_terr", 32'(m_terr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        for (int sc = 0; sc < 4; sc++) begin
            do_reset();
            m_tready = 1'b1;
            tog = (sc == 2);
            for (int i = 0; i < 12; i++) begin
                if (vt[i].sc == sc) begin
                    push_vec(vt[i]);
                    drive(vt[i].w);
                end
            end
            idle();
            wait_drain(300);
            tog = 1'b0;
            @(posedge clk);
            #2;
            m_tready = 1'b1;
            chk($sformatf("sc%0d_frame_cnt", sc), 32'(frame_cnt), (sc == 3) ? 32'd2 : 32'd1);
            chk($sformatf("sc%0d_overflow", sc), 32'(overflow), 32'd0);
        end

        // Overflow with the sink stalled on a depth-4 FIFO.
        do_reset();
        m_tready = 1'b0;
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD8, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push_word(32'h10111213);
        push_word(32'h20212223);
        push_word(32'h30313233);
        push_word(32'h40414243);
        if (ABORT_ON) begin
            push(8'hFF, 1'b0, 1'b0);
            push(8'hD9, 1'b1, 1'b1);
        end
        drive(32'hFFD80102);
        drive(32'h10111213);
        drive(32'h20212223);
        drive(32'h30313233);
        drive(32'h40414243);
        drive(32'h50515253);
        drive(32'h60616263);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("ovf_stall_tvalid", 32'(m_tvalid), 32'd1);
        chk("ovf_stall_tdata", 32'(m_tdata), 32'hFF);
        m_tready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD8, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        push(8'h11, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD9, 1'b1, 1'b0);
        drive(32'hFFD80011);
        drive(32'hFFD90000);
        idle();
        wait_drain(300);
        chk("ovf_frame_cnt", 32'(frame_cnt), ABORT_ON ? 32'd2 : 32'd1);
        chk("ovf_drop_cnt_end", 32'(drop_cnt), 32'd2);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Latency from idle STREAM, then reset mid-frame.
        m_tready = 1'b1;
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD8, 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        push(8'hBB, 1'b0, 1'b0);
        drive(32'hFFD8AABB);
        idle();
        wait_drain(100);
        m_tready = 1'b0;
        drive(32'hCCDDEEFF);
        idle();
        chk("lat_t1_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_t2_tvalid", 32'(m_tvalid), 32'd1);
        chk("lat_t2_tdata", 32'(m_tdata), 32'hCC);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mrst_overflow", 32'(overflow), 32'd0);
        m_tready = 1'b1;
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD8, 1'b0, 1'b0);
        push(8'h12, 1'b0, 1'b0);
        push(8'h34, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        push(8'hD9, 1'b1, 1'b0);
        drive(32'h00FFD812);
        drive(32'h34FFD900);
        idle();
        wait_drain(100);
        chk("mrst_new_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mjpg_byte_streamer.md
Name: mjpg_byte_streamer

Overview:
- Sits directly downstream of the MJPEG encoder. Consumes its 32-bit bitstream words (bsvalid/bsdata) and buffers them in a FIFO.
- Serialises the words into a ready/valid byte stream with per-frame framing for a host link (USB FIFO / UART bridge).
- Frames run SOI to EOI. tlast marks the EOI byte, and bytes outside a frame are discarded.
- The source cannot be back-pressured, so FIFO overflow is handled by dropping words and resynchronising on the next SOI.

Parameters:
- FIFO_AW, 10, log2 of FIFO depth in 32-bit words (depth 1024).
- CNT_W, 16, width of frame_cnt and drop_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- bsvalid  in  1  bitstream word valid, no back-pressure
- bsdata  in  32  bitstream word; byte 0 = [31:24] is first in stream order, byte 3 = [7:0] is last
- m_tvalid  out  1  output byte valid
- m_tready  in  1  sink ready
- m_tdata  out  8  output byte
- m_tlast  out  1  last byte of frame (EOI 0xD9)
- m_terr  out  1  with m_tlast: frame was truncated by overflow
- overflow  out  1  sticky; set on first dropped word, cleared only by rst
- frame_cnt  out  CNT_W  frames completed (tlast handshakes), wraps
- drop_cnt  out  CNT_W  input words dropped, saturates at all-ones

Behaviour:
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, m_terr=0, overflow=0, frame_cnt=0, drop_cnt=0. FIFO empty, input side in PASS, serializer in HUNT, all carried-byte flags cleared.
- Handshake: a byte transfers when m_tvalid&&m_tready. m_tdata, m_tlast and m_terr hold stable while m_tvalid&&!m_tready. m_tvalid never deasserts without a transfer.
- Input side, state PASS:
  - bsvalid with FIFO not full (registered count < depth at start of cycle) → word written.
  - Full → word dropped, drop_cnt+1, overflow=1, go to DROP.
  - Simultaneous read on a full FIFO does not free the slot for the same-cycle write.
- Input side, state DROP:
  - Discard every bsvalid word and count it in drop_cnt.
  - Scan each word for an SOI pair (0xFF then 0xD8), including 0xFF as the last byte of the previous input word.
  - On a hit with FIFO space: write that word, go to PASS.
  - Retain the previous word's last byte across DROP (carry flag).
- Abort entry: FIFO entries are 33 bits (data + abort tag).
  - With the feature on, an abort entry is queued on the DROP→PASS transition, ahead of the SOI word, and takes one FIFO slot.
  - If no slot is free for both abort and SOI word, stay in DROP.
- Serializer, state HUNT:
  - Consume bytes without emitting.
  - Byte 0xFF sets a pending-FF flag. Next byte 0xD8 with the flag set → emit 0xFF, then 0xD8, go to STREAM. Any other byte clears the flag.
  - The flag spans word boundaries.
  - Abort entries are ignored.
- Serializer, state STREAM:
  - Emit every byte in order, tracking the previous byte.
  - Byte 0xD9 following 0xFF → m_tlast=1 on that beat; after its handshake, frame_cnt+1 and go to HUNT.
  - 0xFF00 stuffing and RSTn markers pass through.
  - Abort entry (feature on): emit 0xFF, then 0xD9 with m_tlast=1 and m_terr=1, go to HUNT.
- Latency: FIFO empty, serializer idle in STREAM, m_tready=1:
  - bsvalid at cycle t → byte 0 valid at t+2, bytes 1..3 at t+3..t+5.
  - Sustained throughput is 1 byte/cycle.
- Widths: FIFO pointers FIFO_AW+1 bits; count = wptr-rptr. drop_cnt saturates; frame_cnt wraps modulo 2^CNT_W.
- Reset mid-frame: output stops the cycle after rst is sampled and no partial tlast is generated; the next frame starts at SOI.

Optional Feature:
- Macro MJPG_BYTE_STREAMER_ABORT_EOI_EN.
- Defined: overflow recovery inserts the abort entry, so the truncated frame is closed with synthetic FF D9, tlast=1, terr=1, counted in frame_cnt.
- Undefined: no abort entry, FIFO width 32, m_terr tied 0. The truncated frame is never closed. The serializer stays in STREAM and runs into the next frame's bytes until a real EOI.

Test Plan:
- Reset, then words 0x12FFD9FF, 0xD8AABBCC, 0xFFD90000, m_tready=1 → bytes FF D8 AA BB CC FF D9; tlast on the D9 only; trailing 00 00 discarded; frame_cnt=1.
- SOI split: words 0x000000FF, 0xD8FF0001, 0x02FFD9FF → FF D8 FF 00 01 02 FF D9; stuffed FF00 passes, no tlast on FF00; frame_cnt=1.
- Back-pressure: m_tready toggling 1/0 every cycle through a 3-word frame → every byte held stable while stalled, byte order intact, exactly one tlast.
- Overflow: m_tready=0, FIFO_AW=2, 6 words mid-frame then a word 0xFFD80011 → overflow=1, drop_cnt=2.
  - Feature on: after draining, frame ends FF D9 with tlast=1, terr=1; next frame starts FF D8 00 11.
  - Feature off: no terr and no synthetic FF D9.
- Back-to-back frames of the byte stream FF D8 01 FF D9 FF D8 02 FF D9, packed big-endian into 32-bit words → two frames, frame_cnt=2, no bytes lost between D9 and FF D8.
- rst asserted mid-frame, then a fresh frame → first output byte is FF of the new SOI; counters restart from 0.
